// File: rtl/rm_dup_encoder_if.sv
// Byte-in / RAM-write-out bundle for rm_dup_encoder.
//
// Handshake: a din byte transfers on a rising clk edge where
// din_valid && din_ready are both high. din_valid may rise or fall at any
// time; a byte offered while din_ready is low stays with the producer and is
// not consumed. The write side has no back-pressure: every cycle with wr_en
// high is one RAM write of wr_data at wr_addr.
// dbg_state mirrors the encoder FSM state for checkers.
interface rm_dup_encoder_if #(
  parameter string parameter_set = "hqc128"
);
  localparam int N        = (parameter_set == "hqc256") ? 57637 :
                            (parameter_set == "hqc192") ? 35851 : 17669;
  localparam int RAMDEPTH = (N + 127) / 128;
  localparam int ADDR_W   = $clog2(RAMDEPTH);

  logic              start;
  logic [7:0]        din;
  logic              din_valid;
  logic              din_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [127:0]      wr_data;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  modport master (
    output start, din, din_valid,
    input  din_ready, wr_en, wr_addr, wr_data, busy, done, dbg_state
  );

  modport slave (
    input  start, din, din_valid,
    output din_ready, wr_en, wr_addr, wr_data, busy, done, dbg_state
  );
endinterface

// File: rtl/rm_dup_encoder.sv
// RM(1,7) duplicated inner-code encoder for the HQC encrypt path.
// Each accepted RS byte becomes a 128-bit Reed-Muller codeword that is
// written MULTIPLICITY times to consecutive RAM addresses.
// Optional feature macro: RM_ENC_TAIL_PAD_EN -- when defined, the RAM words
// past the last codeword (up to RAMDEPTH-1) are written with zeros before done.
module rm_dup_encoder #(
  parameter string parameter_set = "hqc128",
  parameter int    RAMWIDTH      = 128
) (
  input  logic             clk,
  input  logic             rst,
  rm_dup_encoder_if.slave  bus
);

  localparam int N1_BYTES     = (parameter_set == "hqc256") ? 90 :
                                (parameter_set == "hqc192") ? 56 : 46;
  localparam int MULTIPLICITY = (parameter_set == "hqc128") ? 3 : 5;
  localparam int N            = (parameter_set == "hqc256") ? 57637 :
                                (parameter_set == "hqc192") ? 35851 : 17669;
  localparam int RAMDEPTH     = (N + RAMWIDTH - 1) / RAMWIDTH;
  localparam int LOG_RAMDEPTH = $clog2(RAMDEPTH);
  localparam int BYTE_W       = $clog2(N1_BYTES);
  localparam int REP_W        = $clog2(MULTIPLICITY + 1);

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N1_BYTES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(MULTIPLICITY - 1);
`ifdef RM_ENC_TAIL_PAD_EN
  localparam logic [LOG_RAMDEPTH-1:0] ADDR_LAST = LOG_RAMDEPTH'(RAMDEPTH - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_FIN   = 3'd3
`ifdef RM_ENC_TAIL_PAD_EN
    ,
    S_PAD   = 3'd4
`endif
  } state_t;

  state_t                  state, state_d;
  logic [RAMWIDTH-1:0]     cw_q;
  logic [BYTE_W-1:0]       byte_cnt;
  logic [REP_W-1:0]        rep;
  logic [LOG_RAMDEPTH-1:0] addr;

  // Codeword bit i is the affine function m[0] ^ <m[7:1], i> over GF(2).
  function automatic logic [RAMWIDTH-1:0] rm_encode(input logic [7:0] m);
    logic [RAMWIDTH-1:0] cw;
    logic [6:0]          idx;
    cw = '0;
    for (int i = 0; i < RAMWIDTH; i++) begin
      idx   = 7'(i);
      cw[i] = m[0] ^ (^(m[7:1] & idx));
    end
    return cw;
  endfunction

  // State register; reset aborts any encode in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d       = state;
    bus.din_ready = 1'b0;
    bus.wr_en     = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        bus.din_ready = 1'b1;
        bus.busy      = 1'b1;
        if (bus.din_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        bus.wr_en = 1'b1;
        bus.busy  = 1'b1;
        if (rep == REP_LAST) begin
          if (byte_cnt == BYTE_LAST) begin
`ifdef RM_ENC_TAIL_PAD_EN
            state_d = S_PAD;
`else
            state_d = S_FIN;
`endif
          end else begin
            state_d = S_LOAD;
          end
        end
      end
`ifdef RM_ENC_TAIL_PAD_EN
      S_PAD: begin
        bus.wr_en = 1'b1;
        bus.busy  = 1'b1;
        if (addr == ADDR_LAST) state_d = S_FIN;
      end
`endif
      S_FIN: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters and codeword register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q     <= '0;
      byte_cnt <= '0;
      rep      <= '0;
      addr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            byte_cnt <= '0;
            addr     <= '0;
          end
        end
        S_LOAD: begin
          if (bus.din_valid) begin
            cw_q <= rm_encode(bus.din);
            rep  <= '0;
          end
        end
        S_WRITE: begin
          addr <= addr + 1'b1;
          rep  <= rep + 1'b1;
          if (rep == REP_LAST && byte_cnt != BYTE_LAST) byte_cnt <= byte_cnt + 1'b1;
        end
`ifdef RM_ENC_TAIL_PAD_EN
        S_PAD: begin
          addr <= addr + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Write port: data and address are only driven while writing; pad words are zero.
  always_comb begin
    bus.wr_addr   = bus.wr_en ? addr : '0;
    bus.wr_data   = (state == S_WRITE) ? cw_q : '0;
    bus.dbg_state = 3'(state);
  end

endmodule

// File: tb/tb_rm_dup_encoder.sv
// Self-checking bench for rm_dup_encoder (hqc128). Expected RAM writes come
// from a behavioural RM(1,7) model driven by the byte streams the bench sends.
module tb_rm_dup_encoder;

  localparam string PSET     = "hqc128";
  localparam int    N1       = (PSET == "hqc256") ? 90 : (PSET == "hqc192") ? 56 : 46;
  localparam int    MULT     = (PSET == "hqc128") ? 3 : 5;
  localparam int    NBITS    = (PSET == "hqc256") ? 57637 : (PSET == "hqc192") ? 35851 : 17669;
  localparam int    RAMDEPTH = (NBITS + 127) / 128;
`ifdef RM_ENC_TAIL_PAD_EN
  localparam int    PAD_N    = RAMDEPTH - N1 * MULT;
`else
  localparam int    PAD_N    = 0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rm_dup_encoder_if #(.parameter_set(PSET)) bus ();
  rm_dup_encoder #(.parameter_set(PSET), .RAMWIDTH(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard state
  logic [127:0] exp_q[$];
  int           exp_addr_q[$];
  logic [7:0]   stream[$];
  int           vectors = 0;
  int           errors  = 0;
  int           done_cnt = 0;
  int           last_wr_cyc = 0;
  int           busy_start = 0;
  logic         prev_busy = 1'b0;
  logic         tp_check = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: start from the constant term, then flip every position whose
  // index has bit (j-1) set for each set message bit j.
  function automatic logic [127:0] model_rm(input logic [7:0] m);
    logic [127:0] w;
    w = m[0] ? {128{1'b1}} : 128'd0;
    for (int j = 1; j < 8; j++)
      if (m[j])
        for (int i = 0; i < 128; i++)
          if (((i >> (j - 1)) % 2) == 1) w[i] = ~w[i];
    return w;
  endfunction

  task automatic push_expect();
    for (int k = 0; k < N1; k++)
      for (int r = 0; r < MULT; r++) begin
        exp_q.push_back(model_rm(stream[k]));
        exp_addr_q.push_back(k * MULT + r);
      end
    for (int p = 0; p < PAD_N; p++) begin
      exp_q.push_back(128'd0);
      exp_addr_q.push_back(N1 * MULT + p);
    end
  endtask

  // Compare process: every write, every done.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 128'(bus.wr_addr), 128'hFFFF);
        end else begin
          logic [127:0] e;
          int a;
          e = exp_q.pop_front();
          a = exp_addr_q.pop_front();
          check("wr_addr", 128'(bus.wr_addr), 128'(a));
          check("wr_data", bus.wr_data, e);
        end
        check("ready_during_write", 128'(bus.din_ready), 128'd0);
        check("busy_during_write", 128'(bus.busy), 128'd1);
        last_wr_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        check("done_after_last_write", 128'(cyc - last_wr_cyc), 128'd1);
        check("writes_left_at_done", 128'(exp_q.size()), 128'd0);
        check("busy_at_done", 128'(bus.busy), 128'd0);
        if (tp_check) check("stream_cycles", 128'(cyc - busy_start), 128'(N1 * (MULT + 1) + PAD_N));
      end
      if (bus.busy && !prev_busy) busy_start = cyc;
      prev_busy = bus.busy;
    end
  end

  // Driver: start pulse, then offer the stream bytes; abort on reset.
  task automatic run_stream(input bit hold_valid);
    int  k, b, d0;
    bit  acc;
    push_expect();
    d0 = done_cnt;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    k = 0;
    b = 0;
    while (k < N1 && b < 4000 && !rst) begin
      bus.din       = stream[k];
      bus.din_valid = hold_valid || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.din_valid && bus.din_ready;
      @(posedge clk); #1;
      if (acc) k++;
      b++;
    end
    bus.din_valid = 1'b0;
    if (!rst && k < N1) check("stream_timeout", 128'(k), 128'(N1));
    b = 0;
    while (done_cnt == d0 && b < 600 && !rst) begin
      @(posedge clk); #1;
      b++;
    end
    if (!rst && done_cnt == d0) check("done_timeout", 128'd0, 128'd1);
  endtask

  task automatic fill_random();
    stream.delete();
    for (int k = 0; k < N1; k++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int d0, b;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.din       = 8'd0;
    bus.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wr_en", 128'(bus.wr_en), 128'd0);
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_done", 128'(bus.done), 128'd0);
    check("reset_din_ready", 128'(bus.din_ready), 128'd0);
    check("reset_wr_addr", 128'(bus.wr_addr), 128'd0);
    check("reset_wr_data", bus.wr_data, 128'd0);
    rst = 1'b0;

    // Hand-computed codewords pin the model.
    check("model_01", model_rm(8'h01), {128{1'b1}});
    check("model_02", model_rm(8'h02), {32{4'hA}});
    check("model_80", model_rm(8'h80), {{64{1'b1}}, 64'd0});
    check("model_03", model_rm(8'h03), {32{4'h5}});

    // All-0x01 stream with din_valid held high: full-rate throughput.
    stream.delete();
    for (int k = 0; k < N1; k++) stream.push_back(8'h01);
    tp_check = 1'b1;
    run_stream(1'b1);
    tp_check = 1'b0;
    repeat (3) @(posedge clk);

    // Fixed leading bytes, random remainder, random valid.
    fill_random();
    stream[0] = 8'h02;
    stream[1] = 8'h80;
    stream[2] = 8'h03;
    run_stream(1'b0);
    repeat (3) @(posedge clk);

    // Start pulses during WRITE and during FIN must be ignored.
    fill_random();
    d0 = done_cnt;
    fork
      run_stream(1'b0);
      begin
        b = 0;
        @(negedge clk);
        while (!bus.wr_en && b < 1000) begin @(negedge clk); b++; end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        b = 0;
        while (!bus.done && b < 2000) begin @(negedge clk); b++; end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("single_done", 128'(done_cnt - d0), 128'd1);
    check("idle_busy_after_fin_start", 128'(bus.busy), 128'd0);
    check("idle_ready_after_fin_start", 128'(bus.din_ready), 128'd0);

    // Reset while writing address 50 aborts the encode.
    fill_random();
    fork
      run_stream(1'b0);
      begin
        b = 0;
        @(negedge clk);
        while (!(bus.wr_en && bus.wr_addr == 50) && b < 2000) begin @(negedge clk); b++; end
        if (b >= 2000) check("addr50_timeout", 128'd0, 128'd1);
        rst = 1'b1;
        #1;
        check("abort_wr_en", 128'(bus.wr_en), 128'd0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        check("abort_din_ready", 128'(bus.din_ready), 128'd0);
        @(posedge clk); #1;
        check("abort_wr_en_next", 128'(bus.wr_en), 128'd0);
        check("abort_busy_next", 128'(bus.busy), 128'd0);
      end
    join
    exp_q.delete();
    exp_addr_q.delete();
    bus.din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Fresh encode after the abort starts again from address 0.
    fill_random();
    run_stream(1'b0);
    repeat (5) @(posedge clk);
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
